// File: rtl/regfile_2r1w.sv
// 2^ADDR_W x WIDTH register file: one write port, two independent read ports,
// optional registered reads with write-to-read bypass, and a sequenced bulk clear.
module regfile_2r1w #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 2,
  parameter int REG_READ = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLKIN,
  input  logic              RESETN,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  WDATA,
  input  logic [ADDR_W-1:0] RADDR0,
  input  logic [ADDR_W-1:0] RADDR1,
  output logic [WIDTH-1:0]  RDATA0,
  output logic [WIDTH-1:0]  RDATA1,
  input  logic              CLR,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic              busy_q;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_acc;
  logic [WIDTH-1:0]  rd_comb0;
  logic [WIDTH-1:0]  rd_comb1;

  // Write handshake: WE is a request, ~BUSY is the ready. A write is taken only
  // on an edge where WE & ~BUSY; a request seen while BUSY is dropped, not held.
  assign wr_acc = WE & ~busy_q;
  assign BUSY   = busy_q;

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CLR) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          // CLR is ignored here; the counter wrap coincides with the return to IDLE.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (busy_q) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      mem[WADDR] <= WDATA;
    end
  end

  // Bypass forwards only accepted user writes; clear writes are never forwarded.
  always_comb begin
    rd_comb0 = mem[RADDR0];
    rd_comb1 = mem[RADDR1];
    if (BYPASS != 0 && wr_acc && WADDR == RADDR0) rd_comb0 = WDATA;
    if (BYPASS != 0 && wr_acc && WADDR == RADDR1) rd_comb1 = WDATA;
  end

  generate
    if (REG_READ != 0) begin : g_reg_read
      logic [WIDTH-1:0] rdata0_q;
      logic [WIDTH-1:0] rdata1_q;

      always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
          rdata0_q <= '0;
          rdata1_q <= '0;
        end else begin
          rdata0_q <= rd_comb0;
          rdata1_q <= rd_comb1;
        end
      end

      assign RDATA0 = rdata0_q;
      assign RDATA1 = rdata1_q;
    end else begin : g_comb_read
      assign RDATA0 = rd_comb0;
      assign RDATA1 = rd_comb1;
    end
  endgenerate

endmodule
